reaction_timer: RTL
===================

# reaction_timer

Millisecond reaction-time measurement stage for the reflex game. It consumes the square-wave timebase from the prescaler (one rising edge per time unit, nominally 1 ms at 50 MHz) and waits a pseudo-random delay before asserting the "go" lamp. It then counts units until the player reacts and presents the result as 4-digit BCD for the display driver. Early presses and counter saturation are flagged.

## Interface
- MIN_WAIT, 1000: fixed part of the go-delay, in time units; must be ≥1.
- RANDOM_EN, 1: 1 adds lfsr[10:0] (0..2047) to the delay; 0 gives a delay of exactly MIN_WAIT.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- tick_in  in  1  timebase square wave, synchronous to clk; each rising edge is one time unit.
- start  in  1  one-cycle pulse, debounced, that starts a round.
- react  in  1  one-cycle pulse, debounced, player button.
- led_go  out  1  go lamp.
- busy  out  1  round in progress.
- done  out  1  one-cycle pulse when a round ends.
- early  out  1  react arrived before go; held until next start.
- overflow  out  1  count saturated at 9999; held until next start.
- time_bcd  out  16  result as {thousands, hundreds, tens, units}, one BCD nibble each.

## Operation
- Edge detect:
  - tick_q <= tick_in; unit = tick_in & ~tick_q.
  - Reset value of tick_q is 0, so a high tick_in at reset release does not produce a unit.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every clk cycle in all states; loads LFSR_SEED on reset.
- States: IDLE, WAIT, RUN, HOLD. Reset state is IDLE.
- IDLE or HOLD, start=1:
  - Load wait_cnt (12 bits) = MIN_WAIT + (RANDOM_EN ? lfsr[10:0] : 0).
  - Clear time_bcd, early and overflow; go to WAIT.
  - start in WAIT or RUN is ignored.
- WAIT:
  - react=1 → early<=1, done pulse, go to HOLD. This takes priority over a unit in the same cycle.
  - Otherwise, on unit: wait_cnt==1 → led_go<=1, go to RUN; else wait_cnt decrements.
  - Net effect: exactly N units from start to go.
- RUN:
  - react=1 → led_go<=0, done pulse, go to HOLD. Count is frozen, and a simultaneous unit is not counted.
  - Otherwise, on unit: increment the 4-digit BCD counter with per-digit carry (9→0 and carry).
  - At 9999, a further unit keeps 9999, sets overflow<=1, clears led_go, pulses done and goes to HOLD.
- HOLD:
  - busy=0; outputs are held until start.
  - react is ignored.
- busy = (state==WAIT) || (state==RUN), registered.
- Reset values: led_go=0, busy=0, done=0, early=0, overflow=0, time_bcd=16'h0000, wait_cnt=0, state=IDLE.
- Reset asserted mid-round returns every output to its reset value immediately (asynchronous); no done pulse is produced.

## Timing
- All outputs are registered.
- start at cycle t → busy=1 at t+1.
- Final unit of the wait at cycle t → led_go=1 at t+1.
- Unit at cycle t in RUN → time_bcd updated at t+1.
- react at cycle t → done=1 for exactly cycle t+1; busy=0 and led_go=0 at t+1; time_bcd is stable from t+1 onward.
- Reported time is the number of unit edges strictly between entering RUN and react, with ±1 unit quantisation.
- start and react in the same cycle from IDLE: start wins and react is ignored.

## Test plan
- Normal round:
  - Setup: RANDOM_EN=0, MIN_WAIT=5, tick_in period 4 clk.
  - Stimulus: start; react after 37 units in RUN.
  - Required: led_go rises 5 units after start; time_bcd=16'h0037; one done pulse; early=0; overflow=0.
- Early press:
  - Stimulus: react 2 units after start.
  - Required: early=1, done pulse, led_go never asserted, time_bcd=0, busy=0 next cycle.
- Saturation:
  - Stimulus: no react for 10000 units in RUN.
  - Required: time_bcd=16'h9999, overflow=1, done pulse, led_go=0.
- Edge cases:
  - react coincident with a unit in RUN at count 0012: result 0012.
  - react coincident with the final wait unit: early=1.
  - start during RUN: no effect.
- Reset mid-RUN:
  - Stimulus: pull rst_n low at count 0500.
  - Required: all outputs zero before the next clk edge.
  - After release: a new start works normally; tick_in held high through reset produces no spurious unit.
- Random delay:
  - Setup: RANDOM_EN=1, MIN_WAIT=1000.
  - Required: 20 rounds with varied start timing give delays within 1000..3047 units and not all equal.

Source files
------------

// File: rtl/reaction_timer.sv
// Reaction-time measurement stage: waits a (pseudo-)random number of
// timebase units before lighting the go lamp, then counts units in BCD
// until the player reacts. Early presses and 9999 saturation are flagged.
module reaction_timer #(
    parameter int unsigned MIN_WAIT  = 1000,
    parameter bit          RANDOM_EN = 1'b1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_in,
    input  logic        start,
    input  logic        react,
    output logic        led_go,
    output logic        busy,
    output logic        done,
    output logic        early,
    output logic        overflow,
    output logic [15:0] time_bcd
);

    typedef enum logic [1:0] {IDLE, WAIT, RUN, HOLD} state_t;

    localparam logic [11:0] MIN_WAIT_W = 12'(MIN_WAIT);

    state_t      state, state_d;
    logic        tick_q;
    logic        unit;
    logic [15:0] lfsr;
    logic [11:0] wait_cnt, wait_cnt_d;
    logic [11:0] delay_load;
    logic        led_go_d, busy_d, done_d, early_d, overflow_d;
    logic [15:0] time_bcd_d;
    logic [15:0] bcd_inc;
    logic        carry;

    // A time unit is a rising edge of the prescaler square wave.
    assign unit = tick_in & ~tick_q;

    // Go-delay loaded at start: fixed part plus optional random part.
    assign delay_load = MIN_WAIT_W + (RANDOM_EN ? {1'b0, lfsr[10:0]} : 12'd0);

    // Remember the previous timebase level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_q <= 1'b0;
        else        tick_q <= tick_in;
    end

    // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifts every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Four-digit BCD increment with ripple carry between digits.
    always_comb begin
        bcd_inc = time_bcd;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (time_bcd[i*4 +: 4] == 4'd9) begin
                    bcd_inc[i*4 +: 4] = 4'd0;
                    carry             = 1'b1;
                end else begin
                    bcd_inc[i*4 +: 4] = time_bcd[i*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Next-state and next-output logic for the round sequencer.
    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        led_go_d   = led_go;
        done_d     = 1'b0;
        early_d    = early;
        overflow_d = overflow;
        time_bcd_d = time_bcd;
        case (state)
            IDLE, HOLD: begin
                if (start) begin
                    wait_cnt_d = delay_load;
                    time_bcd_d = 16'h0000;
                    early_d    = 1'b0;
                    overflow_d = 1'b0;
                    led_go_d   = 1'b0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (react) begin
                    early_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = HOLD;
                end else if (unit) begin
                    if (wait_cnt == 12'd1) begin
                        led_go_d = 1'b1;
                        state_d  = RUN;
                    end else begin
                        wait_cnt_d = wait_cnt - 12'd1;
                    end
                end
            end
            RUN: begin
                if (react) begin
                    led_go_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = HOLD;
                end else if (unit) begin
                    if (time_bcd == 16'h9999) begin
                        overflow_d = 1'b1;
                        led_go_d   = 1'b0;
                        done_d     = 1'b1;
                        state_d    = HOLD;
                    end else begin
                        time_bcd_d = bcd_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WAIT) || (state_d == RUN);
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 12'd0;
            led_go   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            early    <= 1'b0;
            overflow <= 1'b0;
            time_bcd <= 16'h0000;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            led_go   <= led_go_d;
            busy     <= busy_d;
            done     <= done_d;
            early    <= early_d;
            overflow <= overflow_d;
            time_bcd <= time_bcd_d;
        end
    end

endmodule
